// File: rtl/sobol_multi.sv
// Multi-dimensional Sobol point generator: D coordinates advance in parallel by
// Gray-code order (one XOR per dimension per point) behind a valid/ready output.
module sobol_multi #(
    parameter int W = 6,
    parameter int D = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  dir_we,
    input  logic [((D > 1) ? $clog2(D) : 1)-1:0]  dir_dim,
    input  logic [((W > 1) ? $clog2(W) : 1)-1:0]  dir_bit,
    input  logic [W-1:0]                          dir_data,
    input  logic                                  start,
    input  logic                                  out_ready,
    output logic                                  out_valid,
    output logic [D*W-1:0]                        out_data,
    output logic [W-1:0]                          out_index,
    output logic                                  done,
    output logic [1:0]                            o_dbg_state
);

    // Output handshake: a point is transferred on a rising edge where
    // out_valid & out_ready are both high; out_data/out_index stay put otherwise.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_dir [D][W];
    logic [D*W-1:0] r_data;
    logic [D*W-1:0] w_data_nxt;
    logic [D*W-1:0] w_mask;
    logic [W-1:0]   r_index;
    logic [W-1:0]   w_index_nxt;
    logic           w_found;
    logic           w_last;
    logic           w_wr_ok;

    assign w_last  = &r_index;
    assign w_wr_ok = dir_we && (r_state != ST_RUN)
                     && (int'(dir_dim) < D) && (int'(dir_bit) < W);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int d = 0; d < D; d++) begin
                for (int k = 0; k < W; k++) begin
                    r_dir[d][k] <= W'(1) << (W - 1 - k);
                end
            end
        end else if (w_wr_ok) begin
            r_dir[dir_dim][dir_bit] <= dir_data;
        end
    end

    // Column used for the step n -> n+1 is the lowest zero bit of n
    // (trailing-ones count); it is never needed for the all-ones index.
    always_comb begin
        w_mask  = '0;
        w_found = 1'b0;
        for (int k = 0; k < W; k++) begin
            if (!w_found && !r_index[k]) begin
                w_found = 1'b1;
                for (int d = 0; d < D; d++) begin
                    w_mask[d*W +: W] = r_dir[d][k];
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_index_nxt = r_index;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_data_nxt  = '0;
                    w_index_nxt = '0;
                end
            end
            ST_RUN: begin
                if (start) begin
                    w_data_nxt  = '0;
                    w_index_nxt = '0;
                end else if (out_ready) begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_data_nxt  = r_data ^ w_mask;
                        w_index_nxt = r_index + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_index <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_index <= w_index_nxt;
        end
    end

    assign out_valid   = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign out_data    = r_data;
    assign out_index   = r_index;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sobol_multi.sv
// Bench for sobol_multi: expected points come from a direct Gray-code model
// (XOR of direction numbers selected by the bits of n ^ (n >> 1)).
module tb_sobol_multi;

    localparam int W  = 6;
    localparam int D  = 2;
    localparam int EW = W + D*W;

    logic           clk;
    logic           rst;
    logic           dir_we;
    logic [0:0]     dir_dim;
    logic [2:0]     dir_bit;
    logic [W-1:0]   dir_data;
    logic           start;
    logic           out_ready;
    logic           out_valid;
    logic [D*W-1:0] out_data;
    logic [W-1:0]   out_index;
    logic           done;
    logic [1:0]     dbg_state;

    int             n_vec;
    int             n_err;
    logic [EW-1:0]  exp_q[$];
    logic [W-1:0]   m_dir [D][W];
    logic [63:0]    seen;
    logic [EW-1:0]  last_exp;

    sobol_multi #(.W(W), .D(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .dir_we     (dir_we),
        .dir_dim    (dir_dim),
        .dir_bit    (dir_bit),
        .dir_data   (dir_data),
        .start      (start),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_index  (out_index),
        .done       (done),
        .o_dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [D*W-1:0] model_point(input logic [W-1:0] n);
        logic [W-1:0]   g;
        logic [D*W-1:0] x;
        g = n ^ (n >> 1);
        x = '0;
        for (int d = 0; d < D; d++) begin
            for (int k = 0; k < W; k++) begin
                if (g[k]) x[d*W +: W] = x[d*W +: W] ^ m_dir[d][k];
            end
        end
        return x;
    endfunction

    task automatic push_run(input int first, input int count);
        logic [W-1:0] n;
        for (int i = 0; i < count; i++) begin
            n = W'(first + i);
            exp_q.push_back({n, model_point(n)});
        end
    endtask

    task automatic do_reset(input logic rdy, input logic st);
        @(negedge clk);
        rst = 1'b0; out_ready = rdy; start = st; dir_we = 1'b0;
        @(negedge clk);
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        for (int d = 0; d < D; d++)
            for (int k = 0; k < W; k++) m_dir[d][k] = W'(1) << (W - 1 - k);
        exp_q.delete();
        n_vec++;
        if ({out_valid, done, out_index, out_data} !== '0) begin
            n_err++;
            $display("FAIL reset_state: valid=%b done=%b index=%0d data=%h, required all zero",
                     out_valid, done, out_index, out_data);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        out_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if ({out_valid, done, out_index, out_data} !== {1'b1, 1'b0, {W{1'b0}}, {(D*W){1'b0}}}) begin
            n_err++;
            $display("FAIL start_latency: valid=%b done=%b index=%0d data=%h, required valid=1 done=0 index=0 data=0",
                     out_valid, done, out_index, out_data);
        end
    endtask

    task automatic write_dir(input int dim, input int bitk, input logic [W-1:0] data, input logic taken);
        @(negedge clk);
        out_ready = 1'b0;
        dir_we = 1'b1; dir_dim = 1'(dim); dir_bit = 3'(bitk); dir_data = data;
        @(negedge clk);
        dir_we = 1'b0;
        if (taken && dim < D && bitk < W) m_dir[dim][bitk] = data;
    endtask

    // Accepts n_acc points; optionally holds out_ready low for stall_len
    // cycles while stall_at is on out_index.
    task automatic drain(input int n_acc, input int stall_at, input int stall_len, output int cycles);
        int            acc;
        int            stalled;
        logic [EW-1:0] e;
        acc = 0; stalled = 0; cycles = 0;
        while (acc < n_acc && cycles < 4000) begin
            @(negedge clk);
            cycles++;
            if (out_valid && int'(out_index) == stall_at && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
                n_vec++;
                if (exp_q.size() == 0 || {out_index, out_data} !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL stall_hold: index=%0d data=%h, required %h",
                             out_index, out_data, exp_q.size() ? exp_q[0] : '0);
                end
            end else begin
                out_ready = 1'b1;
                if (out_valid) begin
                    acc++;
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL point: unexpected index=%0d data=%h", out_index, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        last_exp = e;
                        seen[out_data[W-1:0]] = 1'b1;
                        if ({out_index, out_data} !== e) begin
                            n_err++;
                            $display("FAIL point: index=%0d data=%h, required index=%0d data=%h",
                                     out_index, out_data, e[EW-1 -: W], e[D*W-1:0]);
                        end
                    end
                end
            end
        end
        if (acc < n_acc) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: accepted %0d, required %0d", acc, n_acc);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0, 1'b0);
    endtask

    task automatic test_default();
        int dflt [5] = '{0, 32, 48, 16, 24};
        int cyc;
        pulse_start();
        for (int i = 0; i < 5; i++)
            exp_q.push_back({W'(i), W'(dflt[i]), W'(dflt[i])});
        drain(5, -1, 0, cyc);
        n_vec++;
        if (cyc !== 5) begin
            n_err++;
            $display("FAIL throughput: %0d cycles for 5 points, required 5", cyc);
        end
        do_reset(1'b0, 1'b0);
    endtask

    task automatic test_dir_load();
        int vals [6] = '{32, 48, 40, 60, 34, 51};
        int d1 [5]   = '{0, 32, 16, 48, 24};
        int d0 [5]   = '{0, 32, 48, 16, 24};
        int cyc;
        for (int k = 0; k < 6; k++) write_dir(1, k, W'(vals[k]), 1'b1);
        write_dir(0, 6, 6'h3f, 1'b1);
        write_dir(0, 7, 6'h3f, 1'b1);
        pulse_start();
        for (int i = 0; i < 5; i++)
            exp_q.push_back({W'(i), W'(d1[i]), W'(d0[i])});
        drain(5, -1, 0, cyc);
        push_run(5, 10);
        drain(10, -1, 0, cyc);
    endtask

    task automatic test_stall();
        int cyc;
        pulse_start();
        push_run(0, 8);
        drain(8, 2, 3, cyc);
        n_vec++;
        if (cyc !== 11) begin
            n_err++;
            $display("FAIL stall_cycles: %0d cycles, required 11", cyc);
        end
    endtask

    task automatic test_full();
        int cyc;
        pulse_start();
        seen = '0;
        push_run(0, 64);
        drain(64, -1, 0, cyc);
        @(negedge clk);
        n_vec++;
        if ({out_valid, done, out_index, out_data} !== {1'b0, 1'b1, last_exp}) begin
            n_err++;
            $display("FAIL done_state: valid=%b done=%b index=%0d data=%h, required valid=0 done=1 point %h",
                     out_valid, done, out_index, out_data, last_exp);
        end
        n_vec++;
        if (seen !== {64{1'b1}}) begin
            n_err++;
            $display("FAIL permutation: dim0 coverage %h, required all ones", seen);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if ({out_valid, done, out_index} !== {1'b0, 1'b1, 6'd63}) begin
            n_err++;
            $display("FAIL done_sticky: valid=%b done=%b index=%0d, required valid=0 done=1 index=63",
                     out_valid, done, out_index);
        end
    endtask

    task automatic test_start_write();
        int cyc;
        @(negedge clk);
        out_ready = 1'b0; start = 1'b1;
        dir_we = 1'b1; dir_dim = 1'b0; dir_bit = 3'd0; dir_data = 6'd5;
        m_dir[0][0] = 6'd5;
        @(negedge clk);
        start = 1'b0; dir_we = 1'b0;
        n_vec++;
        if ({out_valid, done, out_index, out_data} !== {1'b1, 1'b0, {W{1'b0}}, {(D*W){1'b0}}}) begin
            n_err++;
            $display("FAIL start_write_p0: valid=%b done=%b index=%0d data=%h, required valid=1 done=0 index=0 data=0",
                     out_valid, done, out_index, out_data);
        end
        push_run(0, 4);
        drain(4, -1, 0, cyc);
    endtask

    task automatic test_restart();
        int cyc;
        pulse_start();
        push_run(0, 10);
        drain(10, -1, 0, cyc);
        @(negedge clk);
        n_vec++;
        if (out_index !== 6'd10) begin
            n_err++;
            $display("FAIL pre_restart_index: index=%0d, required 10", out_index);
        end
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b0;
        n_vec++;
        if ({out_valid, out_index, out_data} !== {1'b1, {W{1'b0}}, {(D*W){1'b0}}}) begin
            n_err++;
            $display("FAIL restart: valid=%b index=%0d data=%h, required valid=1 index=0 data=0",
                     out_valid, out_index, out_data);
        end
        write_dir(1, 1, 6'h3f, 1'b0);
        write_dir(0, 0, 6'h3f, 1'b0);
        push_run(0, 8);
        drain(8, -1, 0, cyc);
    endtask

    task automatic test_reset_mid();
        int cyc;
        pulse_start();
        push_run(0, 5);
        drain(5, -1, 0, cyc);
        do_reset(1'b1, 1'b1);
        pulse_start();
        push_run(0, 6);
        drain(6, -1, 0, cyc);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b0; dir_we = 1'b0; dir_dim = '0; dir_bit = '0; dir_data = '0;
        start = 1'b0; out_ready = 1'b0; seen = '0; last_exp = '0;
        test_reset();
        test_default();
        test_dir_load();
        test_stall();
        test_full();
        test_start_write();
        test_restart();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sobol_multi.md
SOBOL_MULTI -- requirements
Module: sobol_multi

Interface
REQ-001 SHALL have parameter W, default 6: bit width of each coordinate and of the point index; sequence length is 2^W points.
REQ-002 SHALL have parameter D, default 2: number of dimensions generated in parallel, D >= 1.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-low reset, sampled on rising clk.
REQ-005 SHALL have port dir_we  input  1: direction-number write strobe.
REQ-006 SHALL have port dir_dim  input  max(1,clog2(D)): dimension selected for the write.
REQ-007 SHALL have port dir_bit  input  max(1,clog2(W)): direction-number index k, 0..W-1.
REQ-008 SHALL have port dir_data  input  W: pre-scaled direction number v[d][k] = m[d][k]*2^(W-1-k).
REQ-009 SHALL have port start  input  1: one-cycle pulse that (re)starts the sequence at index 0.
REQ-010 SHALL have port out_ready  input  1: consumer accepts the current point.
REQ-011 SHALL have port out_valid  output  1: out_data/out_index hold a valid point.
REQ-012 SHALL have port out_data  output  D*W: point; dimension d at bits [d*W+W-1 : d*W].
REQ-013 SHALL have port out_index  output  W: sequence index n of the point on out_data.
REQ-014 SHALL have port done  output  1: high after the last point (n = 2^W-1) has been accepted.

Function
REQ-015 SHALL store a D x W table of W-bit direction numbers; a write occurs on the clk edge where dir_we=1, only in IDLE or DONE; writes in RUN are ignored; dir_dim >= D or dir_bit >= W are ignored.
REQ-016 SHALL implement states IDLE, RUN and DONE.
REQ-017 IDLE/DONE: start=1 -> RUN next cycle with out_index=0, out_data=0, out_valid=1, done=0 (latency 1 cycle from start).
REQ-018 RUN: out_valid=1 continuously; out_data and out_index SHALL stay stable while out_ready=0.
REQ-019 RUN: on handshake (out_valid & out_ready) with n < 2^W-1, next cycle SHALL present n+1 and x[d] XOR v[d][c], where c = number of trailing ones of n (Gray-code order), for every d in parallel; throughput 1 point per cycle.
REQ-020 RUN: handshake with n = 2^W-1 -> DONE next cycle: out_valid=0, done=1, out_data/out_index hold the last point; no index wrap.
REQ-021 start=1 in RUN SHALL restart at index 0 next cycle (start has priority over a simultaneous handshake).
REQ-022 start and dir_we in the same IDLE/DONE cycle: write takes effect and the point-0 output is 0 regardless; the new value is used from the first XOR onward.
REQ-023 done SHALL stay 1 in DONE until start or reset.
REQ-024 out_ready is ignored when out_valid=0.

Reset
REQ-025 rst=0 at a clk edge SHALL force IDLE, out_valid=0, done=0, out_data=0, out_index=0, regardless of state, start or handshake.
REQ-026 Reset SHALL load default direction numbers v[d][k] = 2^(W-1-k) for all d, k (van der Corput).
REQ-027 Reset mid-RUN SHALL abort the sequence; the next start restarts from index 0.

Verification
REQ-028 Reset, start, out_ready=1, W=6, D=2 defaults -> dim0 = dim1 = 0,32,48,16,24 at out_index 0..4, one point per cycle.
REQ-029 Load dim1 with 32,48,40,60,34,51 (k=0..5), start, out_ready=1 -> dim1 = 0,32,16,48,24; dim0 unchanged from REQ-028.
REQ-030 Hold out_ready=0 for 3 cycles at index 2 -> out_data/out_index frozen at point 2; resume -> index 3 next cycle with no point skipped or repeated.
REQ-031 Run all 64 points with out_ready=1 -> DONE after index 63 accepted, out_valid=0, done=1; the 64 dim0 values form a permutation of 0..63.
REQ-032 start pulse at index 10 with out_ready=1, then dir_we during RUN -> index 0 / data 0 next cycle; direction table unchanged.
REQ-033 rst=0 for one edge at index 5 -> out_valid=0, out_index=0, done=0, defaults restored next cycle.
